// File: rtl/siso_pkg.sv
// Shared defaults for the serial-in/serial-out shift register.
package siso_pkg;

  localparam int SISO_DEFAULT_WIDTH      = 4;
  localparam int SISO_DEFAULT_SHIFT_LEFT = 1;

endpackage

// File: rtl/siso.sv
// Serial-in shift register with a parallel view and a serial tap on the bit
// that the next shift discards. Direction is fixed at elaboration.
module siso
  import siso_pkg::*;
#(
  parameter int WIDTH      = SISO_DEFAULT_WIDTH,
  parameter int SHIFT_LEFT = SISO_DEFAULT_SHIFT_LEFT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [WIDTH-1:0] dout,
  output logic             sout
);

  logic [WIDTH-1:0] shift_reg;

  // SHIFT_LEFT is a constant, so only one shift path is ever built.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_reg <= '0;
    end else if (SHIFT_LEFT != 0) begin
      shift_reg <= {shift_reg[WIDTH-2:0], din};
    end else begin
      shift_reg <= {din, shift_reg[WIDTH-1:1]};
    end
  end

  assign dout = shift_reg;
  assign sout = (SHIFT_LEFT != 0) ? shift_reg[WIDTH-1] : shift_reg[0];

endmodule

// File: tb/tb_siso.sv
// Directed bench for siso: default left shifter, a right shifter and an
// 8-bit left shifter, each driven by its own reset and data inputs.
module tb_siso;

  logic       clk;
  logic       rst_l, din_l;
  logic       rst_r, din_r;
  logic       rst_w, din_w;
  logic [3:0] dout_l, dout_r;
  logic [7:0] dout_w;
  logic       sout_l, sout_r, sout_w;

  int unsigned checks;
  int unsigned failures;

  siso uut (
    .clk  (clk),
    .rst  (rst_l),
    .din  (din_l),
    .dout (dout_l),
    .sout (sout_l)
  );

  siso #(.WIDTH(4), .SHIFT_LEFT(0)) uut_r (
    .clk  (clk),
    .rst  (rst_r),
    .din  (din_r),
    .dout (dout_r),
    .sout (sout_r)
  );

  siso #(.WIDTH(8), .SHIFT_LEFT(1)) uut_w8 (
    .clk  (clk),
    .rst  (rst_w),
    .din  (din_w),
    .dout (dout_w),
    .sout (sout_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pattern;
  logic [7:0] model_w;
  logic [7:0] sent;

  initial begin
    checks   = 0;
    failures = 0;
    rst_l = 1'b0; din_l = 1'b1;
    rst_r = 1'b0; din_r = 1'b1;
    rst_w = 1'b0; din_w = 1'b1;

    // Reset held for two edges with din=1
    step();
    check("rst1_dout", 64'(dout_l), 64'h0);
    step();
    check("rst2_dout", 64'(dout_l), 64'h0);
    check("rst2_sout", 64'(sout_l), 64'h0);
    check("rst2_probe", 64'(uut.shift_reg), 64'h0);

    // Load 1,0,1,1
    rst_l = 1'b1;
    din_l = 1'b1; step(); check("load1", 64'(dout_l), 64'b0001); check("load1_sout", 64'(sout_l), 64'h0);
    din_l = 1'b0; step(); check("load2", 64'(dout_l), 64'b0010); check("load2_sout", 64'(sout_l), 64'h0);
    din_l = 1'b1; step(); check("load3", 64'(dout_l), 64'b0101); check("load3_sout", 64'(sout_l), 64'h0);
    din_l = 1'b1; step(); check("load4", 64'(dout_l), 64'b1011); check("load4_sout", 64'(sout_l), 64'h1);

    // Flush ones then zeros
    din_l = 1'b1; step(); check("flush1", 64'(dout_l), 64'b0111);
    din_l = 1'b1; step(); check("flush2", 64'(dout_l), 64'b1111);
    din_l = 1'b1; step(); check("flush3", 64'(dout_l), 64'b1111); check("flush3_sout", 64'(sout_l), 64'h1);
    din_l = 1'b0; step(); check("flush4", 64'(dout_l), 64'b1110);
    // Glitches between edges, settling to 0 before the edge
    din_l = 1'b1; #3; din_l = 1'b0; #2; din_l = 1'b1; #2; din_l = 1'b0;
    step(); check("glitch", 64'(dout_l), 64'b1100);

    // Rebuild 1011, then mid-stream reset
    din_l = 1'b1; step(); check("rebuild1", 64'(dout_l), 64'b1001);
    din_l = 1'b0; step(); check("rebuild2", 64'(dout_l), 64'b0010);
    din_l = 1'b1; step(); check("rebuild3", 64'(dout_l), 64'b0101);
    din_l = 1'b1; step(); check("rebuild4", 64'(dout_l), 64'b1011);
    rst_l = 1'b0; din_l = 1'b1; step();
    check("midrst_dout", 64'(dout_l), 64'h0);
    check("midrst_sout", 64'(sout_l), 64'h0);
    rst_l = 1'b1; din_l = 1'b1; step();
    check("resume", 64'(dout_l), 64'b0001);

    // X on din propagates unchanged
    din_l = 1'bx; step();
    check("xprop", 64'(dout_l), {60'h0, 4'b001x});
    din_l = 1'b0; step();
    check("xprop2", 64'(dout_l), {60'h0, 4'b01x0});

    // Right shifter build from reset
    step();
    rst_r = 1'b1;
    din_r = 1'b1; step(); check("right1", 64'(dout_r), 64'b1000); check("right1_sout", 64'(sout_r), 64'h0);
    din_r = 1'b0; step(); check("right2", 64'(dout_r), 64'b0100); check("right2_sout", 64'(sout_r), 64'h0);
    din_r = 1'b1; step(); check("right3", 64'(dout_r), 64'b1010); check("right3_sout", 64'(sout_r), 64'h0);
    din_r = 1'b1; step(); check("right4", 64'(dout_r), 64'b1101); check("right4_sout", 64'(sout_r), 64'h1);
    din_r = 1'b0; step(); check("right5", 64'(dout_r), 64'b0110); check("right5_sout", 64'(sout_r), 64'h0);
    rst_r = 1'b0; step(); check("right_rst", 64'(dout_r), 64'h0);

    // 8-bit sweep: shift in A5 MSB-first, then trail zeros and watch sout
    pattern = 8'hA5;
    model_w = 8'h00;
    sent    = 8'h00;
    check("w8_rst", 64'(dout_w), 64'h0);
    rst_w = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      din_w   = pattern[i];
      model_w = {model_w[6:0], pattern[i]};
      step();
      check("w8_load", 64'(dout_w), 64'(model_w));
    end
    check("w8_full", 64'(dout_w), 64'hA5);
    check("w8_sout_first", 64'(sout_w), 64'h1);
    // Bit sampled at edge k shows on sout after edge k+7
    for (int k = 1; k < 8; k++) begin
      din_w = 1'b0;
      step();
      sent = pattern << k;
      check("w8_sout", 64'(sout_w), 64'(sent[7]));
    end
    check("w8_drained", 64'(dout_w), 64'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
